// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// Registered ALU with iterative unsigned multiply (shift-add) and divide (restoring); HI/LO results.
// Latency: single-cycle ops done one cycle after start, MULTU/DIVU WIDTH+1 edges; start is ignored while busy.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic             ALUSrc,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] extended,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALU_RESULT,
    output logic [WIDTH-1:0] HI,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] b_sel, b_r, hi_r, lo_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] add_res, sub_res, sc_res;
    logic             sc_ovf;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             is_mul, is_div, div_zero, last_iter;

    assign b_sel     = ALUSrc ? extended : readData2;
    assign add_res   = readData1 + b_sel;
    assign sub_res   = readData1 - b_sel;
    assign is_mul    = (ALUControl == OP_MULTU);
    assign is_div    = (ALUControl == OP_DIVU);
    assign div_zero  = (b_sel == '0);
    assign last_iter = (cnt == CNT_W'(1));
    assign busy      = (state != IDLE);

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALUControl)
            OP_AND:  sc_res = readData1 & b_sel;
            OP_OR:   sc_res = readData1 | b_sel;
            OP_XOR:  sc_res = readData1 ^ b_sel;
            OP_NOR:  sc_res = ~(readData1 | b_sel);
            OP_ADD: begin
                sc_res = add_res;
                sc_ovf = (readData1[WIDTH-1] == b_sel[WIDTH-1]) &&
                         (add_res[WIDTH-1] != readData1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_res;
                sc_ovf = (readData1[WIDTH-1] != b_sel[WIDTH-1]) &&
                         (sub_res[WIDTH-1] != readData1[WIDTH-1]);
            end
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(readData1) < $signed(b_sel))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (readData1 < b_sel)};
            default: sc_res = '0;
        endcase
    end

    // hi_r/lo_r are shared: product high/low for MUL, partial remainder/dividend-quotient for DIV
    always_comb begin
        mul_sum    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], lo_r[WIDTH-1:1]};
        div_shift  = {hi_r, lo_r[WIDTH-1]};
        div_diff   = div_shift - {1'b0, b_r};
        div_ge     = ~div_diff[WIDTH];
        div_hi_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_nxt = {lo_r[WIDTH-2:0], div_ge};
        iter_hi    = (state == DIV) ? div_hi_nxt : mul_hi_nxt;
        iter_lo    = (state == DIV) ? div_lo_nxt : mul_lo_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && is_mul)
                    state_nxt = MUL;
                else if (start && is_div && !div_zero)
                    state_nxt = DIV;
            end
            MUL, DIV: begin
                if (last_iter)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            ALU_RESULT <= '0;
            HI         <= '0;
            Zero       <= 1'b0;
            Overflow   <= 1'b0;
            b_r        <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || (is_div && !div_zero)) begin
                            b_r  <= b_sel;
                            lo_r <= readData1;
                            hi_r <= '0;
                            cnt  <= CNT_INIT;
                        end else if (is_div) begin
                            ALU_RESULT <= '1;
                            HI         <= readData1;
                            Zero       <= 1'b0;
                            Overflow   <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            ALU_RESULT <= sc_res;
                            HI         <= '0;
                            Zero       <= (sc_res == '0);
                            Overflow   <= sc_ovf;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt  <= cnt - CNT_W'(1);
                    hi_r <= iter_hi;
                    lo_r <= iter_lo;
                    if (last_iter) begin
                        ALU_RESULT <= iter_lo;
                        HI         <= iter_hi;
                        Zero       <= (iter_lo == '0);
                        Overflow   <= 1'b0;
                        done       <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// Bench for alu_seq: WIDTH=32 and WIDTH=8 instances, queue-based scoreboard on done pulses.
module tb_alu_seq;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100, OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1010, OP_DIVU = 4'b1011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start32, src32, busy32, done32, zero32, ovf32;
    logic [3:0]  op32;
    logic [31:0] a32, r2_32, ext32, lo32, hi32;
    logic        start8, src8, busy8, done8, zero8, ovf8;
    logic [3:0]  op8;
    logic [7:0]  a8, r2_8, ext8, lo8, hi8;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .ALUControl(op32), .ALUSrc(src32),
        .readData1(a32), .readData2(r2_32), .extended(ext32), .busy(busy32), .done(done32),
        .ALU_RESULT(lo32), .HI(hi32), .Zero(zero32), .Overflow(ovf32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ALUControl(op8), .ALUSrc(src8),
        .readData1(a8), .readData2(r2_8), .extended(ext8), .busy(busy8), .done(done8),
        .ALU_RESULT(lo8), .HI(hi8), .Zero(zero8), .Overflow(ovf8)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        int          lat;
        int          sc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int n_done32 = 0, n_done8 = 0, n_exp32 = 0, n_exp8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a_in,
                                   input logic [31:0] b_in, input int w);
        exp_t        e;
        logic [31:0] m, a, b, s, as_, bs_;
        logic [63:0] p;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a = a_in & m;
        b = b_in & m;
        e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.lat = 1; e.sc = 0;
        case (op)
            OP_AND: e.lo = a & b;
            OP_OR:  e.lo = a | b;
            OP_XOR: e.lo = a ^ b;
            OP_NOR: e.lo = ~(a | b) & m;
            OP_ADD: begin
                s = (a + b) & m;
                e.lo = s;
                e.ovf = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
            end
            OP_SUB: begin
                s = (a - b) & m;
                e.lo = s;
                e.ovf = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
            end
            OP_SLT: begin
                as_ = a << (32 - w);
                bs_ = b << (32 - w);
                e.lo = ($signed(as_) < $signed(bs_)) ? 32'd1 : 32'd0;
            end
            OP_SLTU: e.lo = (a < b) ? 32'd1 : 32'd0;
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.lo = p[31:0] & m;
                s = 32'(p >> w);
                e.hi = s & m;
                e.lat = w + 1;
            end
            OP_DIVU: begin
                if (b == 0) begin
                    e.lo = m;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                    e.lat = w + 1;
                end
            end
            default: e.lo = '0;
        endcase
        e.zero = (e.lo == 0);
        return e;
    endfunction

    // Called at a negedge; drives start for exactly one edge, then scrambles operands.
    task automatic issue(input bit is8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] r2, input logic [31:0] ext, input logic src,
                         input bit push);
        exp_t e;
        e = model(op, a, src ? ext : r2, is8 ? 8 : 32);
        e.sc = cyc;
        if (is8) begin
            op8 = op; a8 = a[7:0]; r2_8 = r2[7:0]; ext8 = ext[7:0]; src8 = src; start8 = 1'b1;
            if (push) begin q8.push_back(e); n_exp8++; end
        end else begin
            op32 = op; a32 = a; r2_32 = r2; ext32 = ext; src32 = src; start32 = 1'b1;
            if (push) begin q32.push_back(e); n_exp32++; end
        end
        @(negedge clk);
        start32 = 1'b0; start8 = 1'b0;
        a32 = $urandom; r2_32 = $urandom; ext32 = $urandom;
        a8 = 8'($urandom); r2_8 = 8'($urandom); ext8 = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q32.size() + q8.size()) != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(q32.size() + q8.size()), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("done_busy32", {63'd0, done32 & busy32}, 0);
            if (done32) begin
                n_done32++;
                if (q32.size() > 0) begin
                    e = q32.pop_front();
                    check("lo32", lo32, e.lo);
                    check("hi32", hi32, e.hi);
                    check("zero32", zero32, e.zero);
                    check("ovf32", ovf32, e.ovf);
                    check("lat32", 64'(cyc - e.sc), 64'(e.lat));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("done_busy8", {63'd0, done8 & busy8}, 0);
            if (done8) begin
                n_done8++;
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check("lo8", lo8, e.lo);
                    check("hi8", hi8, e.hi);
                    check("zero8", zero8, e.zero);
                    check("ovf8", ovf8, e.ovf);
                    check("lat8", 64'(cyc - e.sc), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [10];
        int nb;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SUB, OP_SLT, OP_SLTU, OP_MULTU, OP_DIVU};
        reset = 1'b1;
        start32 = 0; op32 = 0; src32 = 0; a32 = 0; r2_32 = 0; ext32 = 0;
        start8 = 0; op8 = 0; src8 = 0; a8 = 0; r2_8 = 0; ext8 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_lo", lo32, 0);
        check("rst_hi", hi32, 0);
        check("rst_zero", zero32, 0);
        check("rst_ovf", ovf32, 0);
        check("rst_lo8", lo8, 0);
        reset = 1'b0;
        @(negedge clk);

        // single-cycle ops, issued back-to-back
        issue(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue(0, OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1);
        issue(0, OP_SLT, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        issue(0, OP_SLTU, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        issue(0, OP_NOR, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        issue(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0, 1);
        issue(0, OP_OR, 32'h1200_0000, 32'h0000_0034, 32'd0, 1'b0, 1);
        issue(0, OP_XOR, 32'hA5A5_A5A5, 32'd0, 32'hFFFF_0000, 1'b1, 1);
        issue(0, OP_SUB, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1);
        issue(0, OP_SUB, 32'd3, 32'd7, 32'd0, 1'b0, 1);
        issue(0, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        issue(0, 4'b0101, 32'h1234_5678, 32'd1, 32'd0, 1'b0, 1);
        drain();

        // MULTU with an ignored mid-op start, then DIVU started in the done cycle
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        repeat (3) @(negedge clk);
        check("mul_busy", busy32, 1);
        op32 = OP_ADD; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 100 && !done32; i++) @(negedge clk);
        check("mul_done_seen", done32, 1);
        issue(0, OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1);
        drain();

        issue(0, OP_DIVU, 32'd9, 32'd0, 32'd0, 1'b0, 1);
        check("div0_busy", busy32, 0);
        drain();

        for (int k = 0; k < 12; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            issue(0, ops[$urandom_range(0, 9)], ra, rb, ~rb, k[0], 1);
            drain();
        end

        // reset in the middle of a multiply
        issue(0, OP_XOR, 32'h1234, 32'd1, 32'd0, 1'b0, 1);
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'h3, 32'd0, 1'b0, 0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy32, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy32, 0);
        check("mid_rst_done", done32, 0);
        check("mid_rst_lo", lo32, 0);
        check("mid_rst_hi", hi32, 0);
        check("mid_rst_zero", zero32, 0);
        @(negedge clk);
        reset = 1'b0;
        nb = n_done32;
        repeat (40) @(negedge clk);
        check("no_done_after_rst", 64'(n_done32), 64'(nb));

        // WIDTH=8 instance
        issue(1, OP_MULTU, 32'hFF, 32'hFF, 32'd0, 1'b0, 1);
        drain();
        issue(1, OP_DIVU, 32'd200, 32'd7, 32'd0, 1'b0, 1);
        drain();
        issue(1, OP_ADD, 32'h7F, 32'h1, 32'd0, 1'b0, 1);
        issue(1, OP_SLT, 32'h1, 32'd0, 32'hFF, 1'b1, 1);
        issue(1, OP_DIVU, 32'd9, 32'd0, 32'd0, 1'b0, 1);
        drain();

        check("q32_empty", 64'(q32.size()), 0);
        check("done_count32", 64'(n_done32), 64'(n_exp32));
        check("done_count8", 64'(n_done8), 64'(n_exp8));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. Adds iterative unsigned multiply and divide, signed overflow detection, unsigned compare, XOR and NOR. Uses a start/busy/done handshake so the multi-cycle control path can stall on long operations. Sits between the register file / immediate extender and the writeback mux, and drives LO (ALU_RESULT) and HI results.

Parameters:
WIDTH, 32, datapath width of operands and results (≥ 4)
CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request: sample operands and ALUControl this edge
ALUControl  input  4  operation select
ALUSrc  input  1  1: B = extended; 0: B = readData2
readData1  input  WIDTH  operand A
readData2  input  WIDTH  register operand B
extended  input  WIDTH  extended immediate operand B
busy  output  1  multi-cycle operation in flight
done  output  1  one-cycle pulse: results valid/updated
ALU_RESULT  output  WIDTH  LO result (logic result / product low / quotient)
HI  output  WIDTH  product high / remainder; 0 for single-cycle ops
Zero  output  1  ALU_RESULT == 0
Overflow  output  1  signed overflow for ADD/SUB; else 0

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, done=0, ALU_RESULT=0, HI=0, Zero=0, Overflow=0; counter and internal operand registers cleared. Reset mid-operation discards the in-flight op; no done is issued.
- B is muxed from ALUSrc at the start edge and latched internally; operand changes after start have no effect.
- Opcodes:
  - 0000 AND, 0001 OR, 0011 XOR, 0100 NOR
  - 0010 ADD, 0110 SUB (modulo 2^WIDTH)
  - 0111 SLT (signed), 1000 SLTU (unsigned); result 1 or 0 zero-extended
  - 1010 MULTU: {HI, ALU_RESULT} = A*B unsigned, 2*WIDTH bits
  - 1011 DIVU: ALU_RESULT = A/B, HI = A%B unsigned
  - Any other code: ALU_RESULT=0, HI=0, Overflow=0, completes as a single-cycle op.
- States: IDLE, MUL, DIV.
- Single-cycle ops: start=1 in IDLE at edge N → all outputs updated at edge N, and done=1 for the cycle following N. State remains IDLE.
- MULTU (shift-add) and DIVU (restoring), start at edge N:
  - Operands load and state→MUL/DIV, busy=1, counter=WIDTH.
  - One iteration per edge on edges N+1 … N+WIDTH.
  - At edge N+WIDTH: results written, busy=0, state→IDLE, done=1 for one cycle.
  - Total latency is WIDTH+1 edges from the start edge to done visible.
- Divide by zero (B=0): no iteration. At the start edge, ALU_RESULT=all ones and HI=A, done next cycle, busy never asserts.
- Overflow: ADD sets it when A and B have the same sign and the result sign differs. SUB sets it when A and B signs differ and the result sign differs from A. It is cleared by every other completion.
- Zero is always recomputed from the new ALU_RESULT at each completion. HI is ignored for Zero.
- Outputs hold their last completed values between completions.
- start while busy=1: ignored, no queuing.
- start in the cycle done=1 is legal (state is IDLE) and is accepted.
- done is never high while busy is high.

Test Plan:
- Reset: assert reset mid-MULTU (busy=1) → same cycle busy=0, done=0, all results 0; no done pulse follows.
- Single-cycle ops: ADD with A=0x7FFFFFFF, B=1 → next cycle ALU_RESULT=0x80000000, Overflow=1, Zero=0, done pulse 1 cycle. SUB with A=5, readData2=5 → ALU_RESULT=0, Zero=1.
- Compares and immediate: ALUSrc=1, extended=0xFFFFFFFF, A=1 → SLT gives 0, SLTU gives 1. NOR of 0 and 0 → 0xFFFFFFFF.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF → busy for 32 cycles, done exactly 33 edges after start with HI=0xFFFFFFFE, ALU_RESULT=0x00000001. A start pulse applied mid-op is ignored.
- DIVU: A=100, B=7 → quotient 14, remainder HI=2 after 32 busy cycles. A=9, B=0 → ALU_RESULT=0xFFFFFFFF, HI=9, done next cycle, busy stays 0.
- Back-to-back and parametrisation: start asserted during the done cycle is accepted. Rerun with WIDTH=8: MULTU 0xFF*0xFF → HI=0xFE, LO=0x01, done 9 edges after start.
